// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: detects the alarm-time edge, rings the LED flasher for a bounded
// period and handles stop, limited snoozes and the alarm on/off switch.
module alarm_ring_ctrl #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter int BLINK_HALF     = 12_500_000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] al_hour,
  input  logic [7:0] al_min,
  input  logic       al_on,
  input  logic       stop,
  input  logic       snooze,
  output logic       en,
  output logic       clk_2,
  output logic [1:0] state,
  output logic [1:0] snooze_left
);

  localparam int SEC_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int TICK_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST       = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   RING_SEC_LAST   = SEC_W'(RING_SECONDS - 1);
  localparam logic [SEC_W-1:0]   SNOOZE_SEC_LAST = SEC_W'(SNOOZE_SECONDS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST      = BLINK_W'(BLINK_HALF - 1);
  localparam logic [1:0]         SNOOZE_LOAD     = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         snl_q, snl_d;
  logic               match_q;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               clk2_q, clk2_d;

  logic match_s;
  logic trigger_s;
  logic tick_wrap_s;
  logic ring_done_s;
  logic snooze_done_s;

  // Alarm only fires on the first cycle of the matching second.
  assign match_s = al_on && (cur_hour == al_hour) && (cur_min == al_min) && (cur_sec == 8'h00);
  assign trigger_s     = match_s && !match_q;
  assign tick_wrap_s   = (tick_q == TICK_LAST);
  assign ring_done_s   = (sec_q == RING_SEC_LAST) && tick_wrap_s;
  assign snooze_done_s = (sec_q == SNOOZE_SEC_LAST) && tick_wrap_s;

  always_comb begin
    state_d = state_q;
    snl_d   = snl_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d = ST_RING;
          snl_d   = SNOOZE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RING: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!al_on) begin
          state_d = ST_IDLE;
        end else if (snooze && (snl_q != 2'd0)) begin
          state_d = ST_SNOOZE;
          snl_d   = snl_q - 2'd1;
        end else if (ring_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (stop || !al_on) begin
          state_d = ST_IDLE;
        end else if (snooze_done_s) begin
          state_d = ST_RING;
        end else begin
          state_d = ST_SNOOZE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        snl_d   = 2'd0;
      end
    endcase
  end

  // Phase timebase restarts on every state change and rests at zero in IDLE.
  always_comb begin
    tick_d = '0;
    sec_d  = '0;
    if ((state_d != state_q) || (state_d == ST_IDLE)) begin
      tick_d = '0;
      sec_d  = '0;
    end else if (tick_wrap_s) begin
      tick_d = '0;
      sec_d  = sec_q + SEC_W'(1);
    end else begin
      tick_d = tick_q + TICK_W'(1);
      sec_d  = sec_q;
    end
  end

  // Blink runs only while staying in RING, so each ring begins with a full low phase.
  always_comb begin
    blink_d = '0;
    clk2_d  = 1'b0;
    if ((state_d == ST_RING) && (state_q == ST_RING)) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        clk2_d  = ~clk2_q;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
        clk2_d  = clk2_q;
      end
    end else begin
      blink_d = '0;
      clk2_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snl_q   <= 2'd0;
      match_q <= 1'b0;
      tick_q  <= '0;
      sec_q   <= '0;
      blink_q <= '0;
      clk2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snl_q   <= snl_d;
      match_q <= match_s;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
      clk2_q  <= clk2_d;
    end
  end

  assign en          = (state_q == ST_RING);
  assign clk_2       = clk2_q;
  assign state       = state_q;
  assign snooze_left = snl_q;

endmodule

// Output invariants of alarm_ring_ctrl, kept apart from the design.
module alarm_ring_ctrl_chk #(
  parameter int MAX_SNOOZE = 3
) (
  input logic       clk,
  input logic       rst,
  input logic       en,
  input logic       clk_2,
  input logic [1:0] state,
  input logic [1:0] snooze_left
);

  a_en_is_ring: assert property (@(posedge clk) disable iff (rst) en == (state == 2'b01));
  a_blink_only_ringing: assert property (@(posedge clk) disable iff (rst) clk_2 |-> en);
  a_state_legal: assert property (@(posedge clk) disable iff (rst) state != 2'b11);
  a_snooze_bound: assert property (@(posedge clk) disable iff (rst)
    32'(snooze_left) <= 32'(MAX_SNOOZE));

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed table, hand-written corner sequences and a
// randomized run against a cycle-count reference model.
module tb_alarm_ring_ctrl;

  localparam int TPS = 4;
  localparam int BH  = 2;
  localparam int RS  = 3;
  localparam int SS  = 2;
  localparam int MS  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cur_hour, cur_min, cur_sec, al_hour, al_min;
  logic       al_on, stop, snooze;
  logic       en, clk_2;
  logic [1:0] state, snooze_left;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int m_st, m_left, m_age, m_snl;
  bit m_prev;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .TICKS_PER_SEC(TPS), .BLINK_HALF(BH), .RING_SECONDS(RS),
    .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .rst(rst), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .al_hour(al_hour), .al_min(al_min), .al_on(al_on), .stop(stop), .snooze(snooze),
    .en(en), .clk_2(clk_2), .state(state), .snooze_left(snooze_left)
  );

  alarm_ring_ctrl_chk #(.MAX_SNOOZE(MS)) u_chk (
    .clk(clk), .rst(rst), .en(en), .clk_2(clk_2), .state(state), .snooze_left(snooze_left)
  );

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       on;
    logic       stp;
    logic       snz;
    logic       e_en;
    logic       e_c2;
    logic [1:0] e_st;
    logic [1:0] e_snl;
  } vec_t;

  vec_t tbl [0:14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour = h;
    cur_min  = m;
    cur_sec  = s;
  endtask

  task automatic chk(input string nm, input logic e_en, input logic e_c2,
                     input logic [1:0] e_st, input logic [1:0] e_snl);
    n_vec++;
    if ({en, clk_2, state, snooze_left} !== {e_en, e_c2, e_st, e_snl}) begin
      n_bad++;
      $display("FAIL %s: got en=%b clk_2=%b state=%b snooze_left=%0d, want en=%b clk_2=%b state=%b snooze_left=%0d",
               nm, en, clk_2, state, snooze_left, e_en, e_c2, e_st, e_snl);
    end
  endtask

  function automatic logic blink_at(input int age);
    return ((age / BH) % 2) == 1;
  endfunction

  // Reset, pass one idle cycle, then present 07:30:00 so the ring starts (age 0).
  task automatic start_ring();
    rst = 1'b1; stop = 1'b0; snooze = 1'b0; al_on = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    rst = 1'b0;
    step();
    chk("pre_idle", 1'b0, 1'b0, 2'b00, 2'd0);
    set_time(8'h07, 8'h30, 8'h00);
    step();
    chk("ring_entry", 1'b1, 1'b0, 2'b01, 2'(MS));
  endtask

  // Reference model: remaining cycles in the current phase plus age since ring entry.
  task automatic model_step();
    bit mt, trig;
    mt = al_on && (cur_hour == al_hour) && (cur_min == al_min) && (cur_sec == 8'h00);
    if (rst) begin
      m_st = 0; m_snl = 0; m_prev = 1'b0; m_left = 0; m_age = 0;
    end else begin
      trig   = mt && !m_prev;
      m_prev = mt;
      if (m_st == 0) begin
        if (trig) begin
          m_st = 1; m_left = RS * TPS; m_age = 0; m_snl = MS;
        end
      end else if (m_st == 1) begin
        if (stop || !al_on) m_st = 0;
        else if (snooze && m_snl != 0) begin
          m_st = 2; m_snl = m_snl - 1; m_left = SS * TPS;
        end else if (m_left == 1) m_st = 0;
        else begin
          m_left = m_left - 1; m_age = m_age + 1;
        end
      end else begin
        if (stop || !al_on) m_st = 0;
        else if (m_left == 1) begin
          m_st = 1; m_left = RS * TPS; m_age = 0;
        end else m_left = m_left - 1;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{8'h29, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0};
    tbl[1]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[2]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[3]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[4]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[5]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[6]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[7]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[8]  = '{8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[9]  = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[10] = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd2};
    tbl[11] = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[12] = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd2};
    tbl[13] = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2};
    tbl[14] = '{8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2};

    al_hour = 8'h07; al_min = 8'h30;
    al_on = 1'b1; stop = 1'b0; snooze = 1'b0;
    set_time(8'h07, 8'h29, 8'h59);
    rst = 1'b1;
    step();
    chk("reset", 1'b0, 1'b0, 2'b00, 2'd0);
    rst = 1'b0;

    // basic ring from the table
    for (int i = 0; i < 15; i++) begin
      set_time(8'h07, tbl[i].mn, tbl[i].sc);
      al_on = tbl[i].on; stop = tbl[i].stp; snooze = tbl[i].snz;
      step();
      chk($sformatf("table[%0d]", i), tbl[i].e_en, tbl[i].e_c2, tbl[i].e_st, tbl[i].e_snl);
    end

    // stop at ring age 5, then no re-ring while 07:30:00 is held
    start_ring();
    for (int a = 1; a <= 5; a++) begin
      step();
      chk("stop_ring", 1'b1, blink_at(a), 2'b01, 2'd2);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_now", 1'b0, 1'b0, 2'b00, 2'd2);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stop_hold", 1'b0, 1'b0, 2'b00, 2'd2);
    end

    // snooze at ring age 3, full snooze, then a full fresh ring
    start_ring();
    for (int a = 1; a <= 3; a++) begin
      step();
      chk("snz_ring", 1'b1, blink_at(a), 2'b01, 2'd2);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snz_enter", 1'b0, 1'b0, 2'b10, 2'd1);
    set_time(8'h07, 8'h30, 8'h05);
    for (int i = 1; i < SS * TPS; i++) begin
      step();
      chk("snz_hold", 1'b0, 1'b0, 2'b10, 2'd1);
    end
    for (int a = 0; a < RS * TPS; a++) begin
      step();
      chk("snz_rering", 1'b1, blink_at(a), 2'b01, 2'd1);
    end
    step();
    chk("snz_done", 1'b0, 1'b0, 2'b00, 2'd1);

    // two snoozes used, a third in RING is ignored
    start_ring();
    set_time(8'h07, 8'h30, 8'h01);
    for (int k = 1; k >= 0; k--) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      chk("x3_snooze", 1'b0, 1'b0, 2'b10, 2'(k));
      for (int i = 1; i < SS * TPS; i++) step();
      step();
      chk("x3_rering", 1'b1, 1'b0, 2'b01, 2'(k));
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("x3_ignored", 1'b1, blink_at(1), 2'b01, 2'd0);
    for (int a = 2; a < RS * TPS; a++) begin
      step();
      chk("x3_ring", 1'b1, blink_at(a), 2'b01, 2'd0);
    end
    step();
    chk("x3_timeout", 1'b0, 1'b0, 2'b00, 2'd0);

    // stop and snooze together: stop wins
    start_ring();
    step();
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    chk("stop_snz", 1'b0, 1'b0, 2'b00, 2'd2);

    // al_on dropping during SNOOZE
    start_ring();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    step();
    chk("off_snz_pre", 1'b0, 1'b0, 2'b10, 2'd1);
    al_on = 1'b0;
    step();
    chk("off_snz", 1'b0, 1'b0, 2'b00, 2'd1);

    // disarmed alarm with matching time never rings
    rst = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    rst = 1'b0;
    set_time(8'h07, 8'h30, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("disarmed", 1'b0, 1'b0, 2'b00, 2'd0);
    end

    // reset mid-ring, then a fresh match edge rings normally
    start_ring();
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    chk("rst_mid", 1'b0, 1'b0, 2'b00, 2'd0);
    rst = 1'b0;
    step();
    set_time(8'h07, 8'h30, 8'h00);
    step();
    chk("rst_rering", 1'b1, 1'b0, 2'b01, 2'd2);
    for (int a = 1; a < RS * TPS; a++) begin
      step();
      chk("rst_ring", 1'b1, blink_at(a), 2'b01, 2'd2);
    end
    step();
    chk("rst_done", 1'b0, 1'b0, 2'b00, 2'd2);

    // randomized run against the reference model
    rst = 1'b1; al_on = 1'b1; stop = 1'b0; snooze = 1'b0;
    model_step();
    step();
    chk("rand_rst", 1'b0, 1'b0, 2'b00, 2'd0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0, 4: set_time(8'h07, 8'h30, 8'h00);
          1:    set_time(8'h07, 8'h30, 8'h01);
          2:    set_time(8'h07, 8'h29, 8'h00);
          default: set_time(8'h08, 8'h30, 8'h00);
        endcase
      end
      if ($urandom_range(0, 59) == 0) al_on = ~al_on;
      stop   = ($urandom_range(0, 29) == 0);
      snooze = ($urandom_range(0, 7) == 0);
      model_step();
      step();
      chk("rand", (m_st == 1), (m_st == 1) ? blink_at(m_age) : 1'b0, 2'(m_st), 2'(m_snl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Alarm sequencer for the digital clock. Compares current BCD time against the stored alarm time and, on a match, drives the LED flasher's enable (`en`) and its blink clock (`clk_2`) for a bounded ring period. Supports stop, a limited number of snoozes, and an alarm on/off switch. Sits between the timekeeping counters and the LED flasher, which lights all LEDs while `en` is high and `clk_2` is low.

## Interface
- TICKS_PER_SEC, 50_000_000, clk cycles per second.
- BLINK_HALF, 12_500_000, clk cycles per `clk_2` half-period.
- RING_SECONDS, 60, ring duration in seconds.
- SNOOZE_SECONDS, 300, snooze duration in seconds.
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cur_hour  in  8  current hour, BCD 00-23.
- cur_min  in  8  current minute, BCD 00-59.
- cur_sec  in  8  current second, BCD 00-59.
- al_hour  in  8  alarm hour, BCD.
- al_min  in  8  alarm minute, BCD.
- al_on  in  1  alarm armed (level).
- stop  in  1  stop request, single-cycle pulse (debounced upstream).
- snooze  in  1  snooze request, single-cycle pulse.
- en  out  1  flasher enable; high exactly while in RING.
- clk_2  out  1  blink square wave to flasher; 0 outside RING.
- state  out  2  00 IDLE, 01 RING, 10 SNOOZE.
- snooze_left  out  2  snoozes remaining in current event.

## Operation
- match = al_on && cur_hour==al_hour && cur_min==al_min && cur_sec==8'h00 (combinational). match_d registers match each cycle; trigger = match && !match_d.
- States:
  - IDLE: trigger -> RING; load snooze_left=MAX_SNOOZE.
  - RING: stop -> IDLE; else !al_on -> IDLE; else snooze && snooze_left!=0 -> SNOOZE, snooze_left-1; else ring time expired -> IDLE. Snooze with snooze_left==0 is ignored.
  - SNOOZE: stop or !al_on -> IDLE; else snooze time expired -> RING. snooze in SNOOZE is ignored. trigger is ignored outside IDLE.
- Priority when simultaneous: rst > stop > !al_on > snooze > timeout.
- Timebase: tick_cnt 0..TICKS_PER_SEC-1 and sec_cnt, both cleared on every state entry. tick_cnt wraps to 0 and sec_cnt increments at TICKS_PER_SEC-1. Counters hold 0 in IDLE.
- Expiry: RING exits when sec_cnt==RING_SECONDS-1 and tick_cnt==TICKS_PER_SEC-1. SNOOZE uses SNOOZE_SECONDS.
- Blink: in RING, blink_cnt counts 0..BLINK_HALF-1 and toggles clk_2 at wrap. On RING entry, blink_cnt=0 and clk_2=0, so each ring starts with LEDs lit. Outside RING, clk_2=0 and blink_cnt=0.
- en = (state==RING), taken from the state register with no extra decode logic.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit. No saturation needed, because counters are cleared on exit.

## Timing
- Reset (synchronous): state=IDLE, en=0, clk_2=0, snooze_left=0, match_d=0, all counters 0.
- Latency: if trigger is true in cycle t, en=1 from t+1. A stop pulse in cycle t gives en=0 from t+1.
- en stays high for exactly RING_SECONDS*TICKS_PER_SEC cycles if undisturbed. SNOOZE lasts exactly SNOOZE_SECONDS*TICKS_PER_SEC cycles.
- clk_2 period is 2*BLINK_HALF cycles. The first low phase is BLINK_HALF cycles.
- A match held for the whole second fires only once (edge detect). Re-arming needs match to deassert.
- al_on dropping mid-ring or mid-snooze -> IDLE on the next edge.
- rst asserted mid-RING -> en=0 on the next edge.

## Test plan
Parameters: TICKS_PER_SEC=4, BLINK_HALF=2, RING_SECONDS=3, SNOOZE_SECONDS=2, MAX_SNOOZE=2.
- Set al_on=1, alarm 07:30, time 07:30:00 held for 8 cycles -> en high from the next cycle for exactly 12 cycles. clk_2 follows 0,0,1,1 repeating. Only one ring occurs, then state=00.
- Ring, then stop pulse at ring cycle 5 -> en=0 and clk_2=0 on the next cycle. No further ring while time stays 07:30:00.
- Ring, then snooze at ring cycle 3 -> state=10 and snooze_left=1 for 8 cycles, then RING for 12 cycles with clk_2 restarting at 0.
- Snooze twice, then a third snooze pulse in RING -> ignored, en stays high, and the ring times out normally.
- Stop and snooze in the same RING cycle -> IDLE. al_on=0 during SNOOZE -> IDLE next cycle. al_on=0 with a matching time -> no ring.
- rst pulse mid-RING -> next cycle all outputs 0 and state=00. A subsequent fresh match edge rings normally.
